multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the reduced RISC-V core; drives the ALU (ALUctrl, ALUsrc) and datapath strobes.
//  Consumes the ALU EQ flag to resolve branches. One instruction in flight.
//  Sits between the instruction register (instr) and the datapath/ALU; counts retired instructions.
// PARAMETERS
//  WIDTH    32  instruction and retire-counter width
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  instr      in   WIDTH  current instruction register contents
//  EQ         in   1      ALU equality flag (ALUop1 == ALUop2)
//  mem_ready  in   1      data memory done (present only with MEM_WAIT_EN)
//  ALUctrl    out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
//  ALUsrc     out  1      0: ALUop2 = rs2, 1: ALUop2 = immediate
//  ImmSrc     out  2      00 I-type, 01 S-type, 10 B-type
//  ResultSrc  out  1      0: write back ALUResult, 1: memory read data
//  IRwrite    out  1      load instr register from fetch
//  PCwrite    out  1      update PC
//  PCsrc      out  1      0: PC+4, 1: branch target (old PC + imm, datapath computed)
//  RegWrite   out  1      register file write strobe
//  MemRead    out  1      data memory read strobe
//  MemWrite   out  1      data memory write strobe
//  retired    out  1      1-cycle pulse on final cycle of each instruction
//  instret    out  WIDTH  retired-instruction count, wraps 2^WIDTH-1 -> 0
//  illegal    out  1      sticky: unsupported instruction decoded
// BEHAVIOUR
//  - Outputs are Moore-style: decoded from state + instr; no comb path from EQ except PCwrite/PCsrc in EXEC for branches.
//  - Reset (async, immediate): state=FETCH, instret=0, illegal=0; while rst=1 every strobe and retired forced 0,
//    ALUctrl=000, ALUsrc=0, ImmSrc=00, ResultSrc=0. Reset mid-instruction abandons it; no partial write after release.
//  - States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
//  - FETCH: IRwrite=1, PCwrite=1, PCsrc=0 -> DECODE.
//  - DECODE: decode instr[6:0]/funct3/funct7. Legal set: addi(0010011/000), add/sub/and/or/slt (0110011,
//    funct7 0000000 or 0100000 for sub only), lw(0000011/010), sw(0100011/010), beq(1100011/000), bne(1100011/001).
//    Illegal -> TRAP; else -> EXEC.
//  - EXEC: R-type ALUsrc=0; addi/lw/sw ALUsrc=1, ALUctrl=000. R/I/lw -> next state; branch: ALUctrl=001, ALUsrc=0,
//    ImmSrc=10; taken (beq&EQ | bne&!EQ) => PCwrite=1, PCsrc=1; retired=1; -> FETCH. lw/sw -> MEM; R/I -> WB.
//  - MEM: lw MemRead=1 -> WB; sw MemWrite=1, ImmSrc=01, retired=1 -> FETCH.
//  - WB: RegWrite=1, ResultSrc=1 for lw else 0, retired=1 -> FETCH.
//  - TRAP: absorbing; all strobes 0, illegal=1, only reset exits.
//  - Latency (cycles, no wait): ALU ops 4, lw 5, sw 4, branch 3. instret increments on the cycle retired=1.
//  - Only one of RegWrite/MemWrite/MemRead high in any cycle; PCwrite never high in MEM or WB.
// CONFIGURATION
//  MEM_WAIT_EN defined: mem_ready port exists; MEM holds (strobes held high, no retire) until mem_ready=1,
//   then transitions as above in that same cycle. mem_ready ignored outside MEM.
//  MEM_WAIT_EN undefined: no mem_ready port; MEM lasts exactly one cycle.
// TESTING
//  addi x1,x0,5 (0x00500093) from reset -> FETCH,DECODE,EXEC,WB; WB: RegWrite=1, ALUsrc=1, ResultSrc=0; instret=1.
//  sub (0x40208133) -> EXEC ALUctrl=001, ALUsrc=0; 4 cycles; retired single pulse.
//  beq EQ=1 -> EXEC PCwrite=1, PCsrc=1; bne EQ=1 -> PCwrite=0; each 3 cycles, instret +1.
//  lw with MEM_WAIT_EN, mem_ready low 3 cycles -> MemRead held 4 cycles, then WB ResultSrc=1; total 8 cycles.
//  instr=0x00000000 -> TRAP after DECODE; illegal=1 sticky; no strobes; instret unchanged; rst clears.
//  rst asserted mid-MEM of sw -> MemWrite drops same cycle; after release FETCH with IRwrite=1, instret=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the reduced RISC-V core: decodes instr, sequences the datapath strobes, counts retires.
// Optional MEM_WAIT_EN adds a mem_ready port; MEM then holds until the data memory reports done.
module multicycle_ctrl_fsm #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr,
   input  logic             EQ,
`ifdef MEM_WAIT_EN
   input  logic             mem_ready,
`endif
   output logic [2:0]       ALUctrl,
   output logic             ALUsrc,
   output logic [1:0]       ImmSrc,
   output logic             ResultSrc,
   output logic             IRwrite,
   output logic             PCwrite,
   output logic             PCsrc,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             retired,
   output logic [WIDTH-1:0] instret,
   output logic             illegal
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        is_alui;
   logic        is_rtype;
   logic        is_lw;
   logic        is_sw;
   logic        is_beq;
   logic        is_bne;
   logic        legal;
   logic        taken;
   logic        mem_done;
   logic [2:0]  alu_ctrl_dec;
   logic        alu_src_dec;
   logic [1:0]  imm_src_dec;
   logic        unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign funct7       = instr[31:25];
   assign unused_instr = ^instr;

`ifdef MEM_WAIT_EN
   assign mem_done = mem_ready;
`else
   assign mem_done = 1'b1;
`endif

   // Instruction decode: legality plus the ALU/immediate controls the instruction needs while in flight
   always_comb begin
      is_alui      = 1'b0;
      is_rtype     = 1'b0;
      is_lw        = 1'b0;
      is_sw        = 1'b0;
      is_beq       = 1'b0;
      is_bne       = 1'b0;
      alu_ctrl_dec = 3'b000;
      alu_src_dec  = 1'b0;
      imm_src_dec  = 2'b00;
      case (opcode)
         7'b0010011: begin
            is_alui     = (funct3 == 3'b000);
            alu_src_dec = 1'b1;
         end
         7'b0110011: begin
            // funct7 0100000 is only meaningful as sub; every other R op needs funct7 all zero
            case (funct3)
               3'b000: begin
                  is_rtype     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                  alu_ctrl_dec = funct7[5] ? 3'b001 : 3'b000;
               end
               3'b111: begin
                  is_rtype     = (funct7 == 7'b0000000);
                  alu_ctrl_dec = 3'b010;
               end
               3'b110: begin
                  is_rtype     = (funct7 == 7'b0000000);
                  alu_ctrl_dec = 3'b011;
               end
               3'b010: begin
                  is_rtype     = (funct7 == 7'b0000000);
                  alu_ctrl_dec = 3'b101;
               end
               default: begin
                  is_rtype     = 1'b0;
               end
            endcase
         end
         7'b0000011: begin
            is_lw       = (funct3 == 3'b010);
            alu_src_dec = 1'b1;
         end
         7'b0100011: begin
            is_sw       = (funct3 == 3'b010);
            alu_src_dec = 1'b1;
            imm_src_dec = 2'b01;
         end
         7'b1100011: begin
            is_beq       = (funct3 == 3'b000);
            is_bne       = (funct3 == 3'b001);
            alu_ctrl_dec = 3'b001;
            imm_src_dec  = 2'b10;
         end
         default: begin
            alu_ctrl_dec = 3'b000;
         end
      endcase
   end

   assign legal = is_alui | is_rtype | is_lw | is_sw | is_beq | is_bne;
   assign taken = (is_beq & EQ) | (is_bne & ~EQ);

   // Next-state and strobe decode; reset forces every output to its idle value
   always_comb begin
      next_state = state;
      ALUctrl    = 3'b000;
      ALUsrc     = 1'b0;
      ImmSrc     = 2'b00;
      ResultSrc  = 1'b0;
      IRwrite    = 1'b0;
      PCwrite    = 1'b0;
      PCsrc      = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      retired    = 1'b0;
      if (rst) begin
         next_state = FETCH;
      end else begin
         case (state)
            FETCH: begin
               IRwrite    = 1'b1;
               PCwrite    = 1'b1;
               next_state = DECODE;
            end
            DECODE: begin
               next_state = legal ? EXEC : TRAP;
            end
            EXEC: begin
               ALUctrl = alu_ctrl_dec;
               ALUsrc  = alu_src_dec;
               ImmSrc  = imm_src_dec;
               if (is_beq || is_bne) begin
                  PCwrite    = taken;
                  PCsrc      = taken;
                  retired    = 1'b1;
                  next_state = FETCH;
               end else if (is_lw || is_sw) begin
                  next_state = MEM;
               end else begin
                  next_state = WB;
               end
            end
            MEM: begin
               ALUctrl = alu_ctrl_dec;
               ALUsrc  = alu_src_dec;
               ImmSrc  = imm_src_dec;
               if (is_lw) begin
                  MemRead    = 1'b1;
                  next_state = mem_done ? WB : MEM;
               end else begin
                  MemWrite   = 1'b1;
                  retired    = mem_done;
                  next_state = mem_done ? FETCH : MEM;
               end
            end
            WB: begin
               ALUctrl    = alu_ctrl_dec;
               ALUsrc     = alu_src_dec;
               ImmSrc     = imm_src_dec;
               RegWrite   = 1'b1;
               ResultSrc  = is_lw;
               retired    = 1'b1;
               next_state = FETCH;
            end
            TRAP: begin
               next_state = TRAP;
            end
            default: begin
               next_state = FETCH;
            end
         endcase
      end
   end

   // State register, retire counter and sticky illegal flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= FETCH;
         instret <= '0;
         illegal <= 1'b0;
      end else begin
         state <= next_state;
         if (retired) begin
            instret <= instret + WIDTH'(1);
         end else begin
            instret <= instret;
         end
         if ((state == DECODE) && !legal) begin
            illegal <= 1'b1;
         end else begin
            illegal <= illegal;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm: per-state strobes, latencies, branches, traps, resets.
// Inputs change 1 ns after the rising edge and outputs are sampled there, away from the edge.
module tb_multicycle_ctrl_fsm;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        EQ;
`ifdef MEM_WAIT_EN
   logic        mem_ready;
`endif
   logic [2:0]  ALUctrl;
   logic        ALUsrc;
   logic [1:0]  ImmSrc;
   logic        ResultSrc;
   logic        IRwrite;
   logic        PCwrite;
   logic        PCsrc;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        retired;
   logic [31:0] instret;
   logic        illegal;

   int total;
   int bad;
   int exp_cnt;

   multicycle_ctrl_fsm #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .EQ        (EQ),
`ifdef MEM_WAIT_EN
      .mem_ready (mem_ready),
`endif
      .ALUctrl   (ALUctrl),
      .ALUsrc    (ALUsrc),
      .ImmSrc    (ImmSrc),
      .ResultSrc (ResultSrc),
      .IRwrite   (IRwrite),
      .PCwrite   (PCwrite),
      .PCsrc     (PCsrc),
      .RegWrite  (RegWrite),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .retired   (retired),
      .instret   (instret),
      .illegal   (illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      if (obs !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] r_ins [4]  = '{32'h40208133, 32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3};
   logic [2:0]  r_alu [4]  = '{3'b001, 3'b010, 3'b011, 3'b101};
   logic [31:0] b_ins [4]  = '{32'h00208063, 32'h00208063, 32'h00209063, 32'h00209063};
   logic        b_eq  [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
   logic        b_tk  [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
   logic [31:0] bad_ins [4] = '{32'h00000000, 32'h4020F1B3, 32'h00008283, 32'h00501093};

   initial begin
      total   = 0;
      bad     = 0;
      exp_cnt = 0;
      rst     = 1'b1;
      instr   = 32'h00000000;
      EQ      = 1'b0;
`ifdef MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      #1;
      chk("rst_irwrite", IRwrite, 32'd0);
      chk("rst_pcwrite", PCwrite, 32'd0);
      chk("rst_aluctrl", ALUctrl, 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_illegal", illegal, 32'd0);

      // addi x1,x0,5
      tick();
      rst   = 1'b0;
      instr = 32'h00500093;
      #1;
      chk("addi_f_irwrite", IRwrite, 32'd1);
      chk("addi_f_pcwrite", PCwrite, 32'd1);
      chk("addi_f_pcsrc", PCsrc, 32'd0);
      tick();
      chk("addi_d_irwrite", IRwrite, 32'd0);
      chk("addi_d_pcwrite", PCwrite, 32'd0);
      tick();
      chk("addi_e_alusrc", ALUsrc, 32'd1);
      chk("addi_e_aluctrl", ALUctrl, 32'd0);
      chk("addi_e_retired", retired, 32'd0);
      tick();
      chk("addi_w_regwrite", RegWrite, 32'd1);
      chk("addi_w_alusrc", ALUsrc, 32'd1);
      chk("addi_w_resultsrc", ResultSrc, 32'd0);
      chk("addi_w_retired", retired, 32'd1);
      tick();
      exp_cnt = 1;
      chk("addi_instret", instret, 32'd1);
      chk("addi_next_irwrite", IRwrite, 32'd1);

      // R-type: sub, and, or, slt -- four cycles each
      for (int i = 0; i < 4; i++) begin
         instr = r_ins[i];
         tick();
         tick();
         chk("r_e_aluctrl", ALUctrl, 32'(r_alu[i]));
         chk("r_e_alusrc", ALUsrc, 32'd0);
         chk("r_e_retired", retired, 32'd0);
         tick();
         chk("r_w_retired", retired, 32'd1);
         chk("r_w_regwrite", RegWrite, 32'd1);
         tick();
         exp_cnt = exp_cnt + 1;
         chk("r_f_retired", retired, 32'd0);
         chk("r_f_irwrite", IRwrite, 32'd1);
         chk("r_instret", instret, 32'(exp_cnt));
      end

      // beq/bne with EQ both ways -- three cycles each
      for (int i = 0; i < 4; i++) begin
         instr = b_ins[i];
         EQ    = b_eq[i];
         tick();
         chk("br_d_pcwrite", PCwrite, 32'd0);
         tick();
         chk("br_e_pcwrite", PCwrite, 32'(b_tk[i]));
         chk("br_e_pcsrc", PCsrc, 32'(b_tk[i]));
         chk("br_e_retired", retired, 32'd1);
         chk("br_e_aluctrl", ALUctrl, 32'd1);
         chk("br_e_immsrc", ImmSrc, 32'd2);
         chk("br_e_alusrc", ALUsrc, 32'd0);
         tick();
         exp_cnt = exp_cnt + 1;
         chk("br_f_irwrite", IRwrite, 32'd1);
         chk("br_instret", instret, 32'(exp_cnt));
      end
      EQ = 1'b0;

      // lw x5,0(x1)
      instr = 32'h0000A283;
`ifdef MEM_WAIT_EN
      mem_ready = 1'b0;
`endif
      tick();
      tick();
      chk("lw_e_alusrc", ALUsrc, 32'd1);
      chk("lw_e_memread", MemRead, 32'd0);
      tick();
      chk("lw_m_memread", MemRead, 32'd1);
      chk("lw_m_regwrite", RegWrite, 32'd0);
      chk("lw_m_pcwrite", PCwrite, 32'd0);
      chk("lw_m_retired", retired, 32'd0);
`ifdef MEM_WAIT_EN
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("lw_wait_memread", MemRead, 32'd1);
         chk("lw_wait_retired", retired, 32'd0);
      end
      mem_ready = 1'b1;
      #1;
      chk("lw_ready_memread", MemRead, 32'd1);
`endif
      tick();
      chk("lw_w_regwrite", RegWrite, 32'd1);
      chk("lw_w_resultsrc", ResultSrc, 32'd1);
      chk("lw_w_memread", MemRead, 32'd0);
      chk("lw_w_retired", retired, 32'd1);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("lw_instret", instret, 32'(exp_cnt));
      chk("lw_f_irwrite", IRwrite, 32'd1);

      // sw x2,4(x1)
      instr = 32'h0020A223;
      tick();
      tick();
      chk("sw_e_alusrc", ALUsrc, 32'd1);
      chk("sw_e_memwrite", MemWrite, 32'd0);
      tick();
      chk("sw_m_memwrite", MemWrite, 32'd1);
      chk("sw_m_immsrc", ImmSrc, 32'd1);
      chk("sw_m_retired", retired, 32'd1);
      chk("sw_m_pcwrite", PCwrite, 32'd0);
      chk("sw_m_regwrite", RegWrite, 32'd0);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("sw_instret", instret, 32'(exp_cnt));
      chk("sw_f_irwrite", IRwrite, 32'd1);

      // illegal encodings trap, stay trapped, and only reset clears them
      for (int i = 0; i < 4; i++) begin
         instr = bad_ins[i];
         tick();
         chk("ill_d_illegal", illegal, 32'd0);
         tick();
         chk("ill_t_illegal", illegal, 32'd1);
         chk("ill_t_irwrite", IRwrite, 32'd0);
         chk("ill_t_pcwrite", PCwrite, 32'd0);
         chk("ill_t_retired", retired, 32'd0);
         tick();
         tick();
         chk("ill_hold_illegal", illegal, 32'd1);
         chk("ill_hold_regwrite", RegWrite, 32'd0);
         chk("ill_hold_irwrite", IRwrite, 32'd0);
         chk("ill_hold_instret", instret, 32'(exp_cnt));
         rst = 1'b1;
         #1;
         chk("ill_rst_illegal", illegal, 32'd0);
         chk("ill_rst_instret", instret, 32'd0);
         tick();
         rst = 1'b0;
         #1;
         exp_cnt = 0;
         chk("ill_rel_irwrite", IRwrite, 32'd1);
      end

      // reset during the MEM cycle of a store
      instr = 32'h0020A223;
      tick();
      tick();
      tick();
      chk("swrst_m_memwrite", MemWrite, 32'd1);
      rst = 1'b1;
      #1;
      chk("swrst_memwrite", MemWrite, 32'd0);
      chk("swrst_retired", retired, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("swrst_f_irwrite", IRwrite, 32'd1);
      chk("swrst_instret", instret, 32'd0);
      chk("swrst_memwrite_after", MemWrite, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
